// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding, RV32I -> ALU op decode, valid/ready hold.
// Optional feature: define ID_EX_FORWARD_EN to enable EX/MEM and MEM/WB operand forwarding.
module id_ex_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      in_opcode,
   input  logic [2:0]      in_funct3,
   input  logic            in_funct7_5,
   input  logic [4:0]      in_rs1,
   input  logic [4:0]      in_rs2,
   input  logic [4:0]      in_rd,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   input  logic            ex_fwd_valid,
   input  logic [4:0]      ex_fwd_rd,
   input  logic [XLEN-1:0] ex_fwd_data,
   input  logic            wb_fwd_valid,
   input  logic [4:0]      wb_fwd_rd,
   input  logic [XLEN-1:0] wb_fwd_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_op,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_rs2_data,
   output logic            out_illegal
);
   localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                          OP_OR  = 4'b0011, OP_XOR = 4'b0100, OP_SLT = 4'b0101,
                          OP_SLL = 4'b0110, OP_SRL = 4'b0111, OP_SRA = 4'b1000,
                          OP_SLTU = 4'b1001;

   localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LUI = 7'b0110111,
                          OPC_AUIPC = 7'b0010111, OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011,
                          OPC_BRANCH = 7'b1100011, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111;

   logic [XLEN-1:0] rs1_fwd, rs2_fwd;

`ifdef ID_EX_FORWARD_EN
   // EX/MEM is younger than MEM/WB, so it wins when both target the same register.
   always_comb begin
      rs1_fwd = in_rs1_data;
      if (ex_fwd_valid && ex_fwd_rd == in_rs1 && in_rs1 != 5'd0)      rs1_fwd = ex_fwd_data;
      else if (wb_fwd_valid && wb_fwd_rd == in_rs1 && in_rs1 != 5'd0) rs1_fwd = wb_fwd_data;
      rs2_fwd = in_rs2_data;
      if (ex_fwd_valid && ex_fwd_rd == in_rs2 && in_rs2 != 5'd0)      rs2_fwd = ex_fwd_data;
      else if (wb_fwd_valid && wb_fwd_rd == in_rs2 && in_rs2 != 5'd0) rs2_fwd = wb_fwd_data;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{ex_fwd_valid, ex_fwd_rd, ex_fwd_data, wb_fwd_valid, wb_fwd_rd,
                         wb_fwd_data, in_rs1, in_rs2};
   assign rs1_fwd = in_rs1_data;
   assign rs2_fwd = in_rs2_data;
`endif

   function automatic logic [3:0] f3_to_op(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  f3_to_op = alt ? OP_SUB : OP_ADD;
         3'b001:  f3_to_op = OP_SLL;
         3'b010:  f3_to_op = OP_SLT;
         3'b011:  f3_to_op = OP_SLTU;
         3'b100:  f3_to_op = OP_XOR;
         3'b101:  f3_to_op = alt ? OP_SRA : OP_SRL;
         3'b110:  f3_to_op = OP_OR;
         default: f3_to_op = OP_AND;
      endcase
   endfunction

   logic [XLEN-1:0] dec_a, dec_b;
   logic [3:0]      dec_op;
   logic [4:0]      dec_rd;
   logic            dec_ill;

   always_comb begin
      dec_a   = rs1_fwd;
      dec_b   = rs2_fwd;
      dec_op  = OP_ADD;
      dec_rd  = in_rd;
      dec_ill = 1'b0;
      case (in_opcode)
         OPC_OP:    dec_op = f3_to_op(in_funct3, in_funct7_5);
         OPC_OPIMM: begin
            dec_b  = in_imm;
            // funct7_5 is part of the immediate except for the shift-right pair.
            dec_op = f3_to_op(in_funct3, in_funct7_5 && in_funct3 == 3'b101);
         end
         OPC_LUI:   begin dec_a = '0;    dec_b = in_imm; end
         OPC_AUIPC: begin dec_a = in_pc; dec_b = in_imm; end
         OPC_LOAD:  dec_b = in_imm;
         OPC_STORE: begin dec_b = in_imm; dec_rd = 5'd0; end
         OPC_BRANCH: begin
            dec_rd = 5'd0;
            dec_op = !in_funct3[2] ? OP_SUB : (in_funct3[1] ? OP_SLTU : OP_SLT);
         end
         OPC_JAL, OPC_JALR: begin dec_a = in_pc; dec_b = XLEN'(4); end
         default: begin
            dec_ill = 1'b1;
            dec_a   = '0;
            dec_b   = '0;
            dec_rd  = 5'd0;
         end
      endcase
   end

   logic            valid_q, valid_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d, pc_q, pc_d, rs2_q, rs2_d;
   logic [3:0]      op_q, op_d;
   logic [4:0]      rd_q, rd_d;
   logic            ill_q, ill_d;
   logic            capture;

   assign in_ready = ~valid_q | out_ready;
   assign capture  = in_valid & in_ready & ~flush;

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      pc_d  = pc_q;
      rs2_d = rs2_q;
      op_d  = op_q;
      rd_d  = rd_q;
      ill_d = ill_q;
      if (capture) begin
         a_d   = dec_a;
         b_d   = dec_b;
         pc_d  = in_pc;
         rs2_d = rs2_fwd;
         op_d  = dec_op;
         rd_d  = dec_rd;
         ill_d = dec_ill;
      end
      valid_d = ~flush & (capture | (valid_q & ~out_ready));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         pc_q    <= '0;
         rs2_q   <= '0;
         op_q    <= OP_ADD;
         rd_q    <= 5'd0;
         ill_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         pc_q    <= pc_d;
         rs2_q   <= rs2_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         ill_q   <= ill_d;
      end
   end

   assign out_valid    = valid_q;
   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign alu_op       = op_q;
   assign out_rd       = rd_q;
   assign out_pc       = pc_q;
   assign out_rs2_data = rs2_q;
   assign out_illegal  = ill_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: spec-level model checked every cycle plus directed literal checks.
module tb_id_ex_stage;
   localparam int XLEN = 32;
`ifdef ID_EX_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid, in_ready, in_funct7_5, flush;
   logic [6:0] in_opcode;
   logic [2:0] in_funct3;
   logic [4:0] in_rs1, in_rs2, in_rd;
   logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
   logic ex_fwd_valid, wb_fwd_valid;
   logic [4:0] ex_fwd_rd, wb_fwd_rd;
   logic [XLEN-1:0] ex_fwd_data, wb_fwd_data;
   logic out_valid, out_ready, out_illegal;
   logic [XLEN-1:0] alu_a, alu_b, out_pc, out_rs2_data;
   logic [3:0] alu_op;
   logic [4:0] out_rd;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_pc(in_pc),
      .flush(flush),
      .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
      .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
      .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .out_rd(out_rd), .out_pc(out_pc), .out_rs2_data(out_rs2_data),
      .out_illegal(out_illegal)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---- behavioural model ----
   typedef struct packed {
      logic [XLEN-1:0] a, b, pc, rs2;
      logic [3:0]      op;
      logic [4:0]      rd;
      logic            ill;
   } exp_t;

   exp_t m_q = '0;
   logic m_valid = 1'b0;

   function automatic logic [XLEN-1:0] fwd(input logic [4:0] rs, input logic [XLEN-1:0] rf);
      if (FWD && rs != 5'd0 && ex_fwd_valid && ex_fwd_rd == rs) return ex_fwd_data;
      if (FWD && rs != 5'd0 && wb_fwd_valid && wb_fwd_rd == rs) return wb_fwd_data;
      return rf;
   endfunction

   // ALU names: ADD 0 SUB 1 AND 2 OR 3 XOR 4 SLT 5 SLL 6 SRL 7 SRA 8 SLTU 9
   function automatic logic [3:0] arith(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0: return alt ? 4'd1 : 4'd0;
         3'd1: return 4'd6;
         3'd2: return 4'd5;
         3'd3: return 4'd9;
         3'd4: return 4'd4;
         3'd5: return alt ? 4'd8 : 4'd7;
         3'd6: return 4'd3;
         default: return 4'd2;
      endcase
   endfunction

   function automatic exp_t model();
      exp_t e;
      logic [XLEN-1:0] r1, r2;
      r1 = fwd(in_rs1, in_rs1_data);
      r2 = fwd(in_rs2, in_rs2_data);
      e.pc = in_pc; e.rs2 = r2; e.rd = in_rd; e.ill = 1'b0; e.op = 4'd0;
      e.a = r1; e.b = in_imm;
      case (in_opcode)
         7'h33: begin e.b = r2; e.op = arith(in_funct3, in_funct7_5); end
         7'h13: e.op = arith(in_funct3, (in_funct3 == 3'd5) ? in_funct7_5 : 1'b0);
         7'h37: e.a = 0;
         7'h17: e.a = in_pc;
         7'h03: ;
         7'h23: e.rd = 0;
         7'h63: begin
            e.b = r2; e.rd = 0;
            e.op = (in_funct3 < 3'd4) ? 4'd1 : (in_funct3 < 3'd6) ? 4'd5 : 4'd9;
         end
         7'h6F, 7'h67: begin e.a = in_pc; e.b = 4; end
         default: begin e.a = 0; e.b = 0; e.rd = 0; e.ill = 1'b1; end
      endcase
      return e;
   endfunction

   wire m_take = in_valid && (!m_valid || out_ready) && !flush;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_q     <= '0;
      end else begin
         if (m_take) m_q <= model();
         m_valid <= m_take || (m_valid && !out_ready && !flush);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         chk("alu_a", alu_a, m_q.a);
         chk("alu_b", alu_b, m_q.b);
         chk("alu_op", 32'(alu_op), 32'(m_q.op));
         chk("out_rd", 32'(out_rd), 32'(m_q.rd));
         chk("out_pc", out_pc, m_q.pc);
         chk("out_rs2_data", out_rs2_data, m_q.rs2);
         chk("out_illegal", 32'(out_illegal), 32'(m_q.ill));
      end
   end

   // ---- directed stimulus ----
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [31:0] pc);
      in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_funct7_5 = f75;
      in_rs1 = r1; in_rs2 = r2; in_rd = rd;
      in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_pc = pc;
   endtask

   task automatic fwd_set(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                          input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
      ex_fwd_valid = ev; ex_fwd_rd = erd; ex_fwd_data = ed;
      wb_fwd_valid = wv; wb_fwd_rd = wrd; wb_fwd_data = wd;
   endtask

   initial begin
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(7'h33, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
      in_valid = 1'b0;
      fwd_set(1'b0, 5'd0, 0, 1'b0, 5'd0, 0);
      #1 rst = 1'b1;
      #1 cmp_en = 1'b1;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset alu_a", alu_a, 32'd0);
      chk("reset alu_op", 32'(alu_op), 32'd0);
      chk("reset out_illegal", 32'(out_illegal), 32'd0);
      step(); step();
      rst = 1'b0; out_ready = 1'b1;

      // OP ADD
      drive(7'h33, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd3, 32'd0, 32'h10);
      step();
      chk("add out_valid", 32'(out_valid), 32'd1);
      chk("add alu_a", alu_a, 32'd5);
      chk("add alu_b", alu_b, 32'd3);
      chk("add alu_op", 32'(alu_op), 32'b0000);

      // SRAI then SRLI
      drive(7'h13, 3'b101, 1'b1, 5'd1, 5'd2, 5'd4, 32'h8000_0000, 32'd9, 32'd4, 32'h14);
      step();
      chk("srai alu_op", 32'(alu_op), 32'b1000);
      chk("srai alu_b", alu_b, 32'd4);
      in_funct7_5 = 1'b0;
      step();
      chk("srli alu_op", 32'(alu_op), 32'b0111);
      // ADDI with bit 30 set stays ADD; OP with bit 30 is SUB
      drive(7'h13, 3'b000, 1'b1, 5'd1, 5'd2, 5'd4, 32'd7, 32'd1, 32'hFFFF_FC00, 32'h18);
      step();
      chk("addi alu_op", 32'(alu_op), 32'b0000);
      drive(7'h33, 3'b000, 1'b1, 5'd1, 5'd2, 5'd4, 32'd7, 32'd1, 32'd0, 32'h1C);
      step();
      chk("sub alu_op", 32'(alu_op), 32'b0001);

      // Hold
      drive(7'h33, 3'b111, 1'b0, 5'd1, 5'd2, 5'd9, 32'hF0, 32'h3C, 32'd0, 32'h20);
      step();
      out_ready = 1'b0;
      drive(7'h33, 3'b110, 1'b0, 5'd1, 5'd2, 5'd10, 32'h1, 32'h2, 32'd0, 32'h24);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold in_ready", 32'(in_ready), 32'd0);
         chk("hold alu_op", 32'(alu_op), 32'b0010);
         chk("hold out_rd", 32'(out_rd), 32'd9);
      end
      out_ready = 1'b1;
      step();
      chk("after hold alu_op", 32'(alu_op), 32'b0011);
      chk("after hold out_rd", 32'(out_rd), 32'd10);

      // Forwarding
      drive(7'h33, 3'b000, 1'b0, 5'd7, 5'd2, 5'd3, 32'h11, 32'h22, 32'd0, 32'h28);
      fwd_set(1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB);
      step();
      chk("fwd ex prio alu_a", alu_a, FWD ? 32'hAA : 32'h11);
      drive(7'h33, 3'b000, 1'b0, 5'd0, 5'd0, 5'd3, 32'h33, 32'h44, 32'd0, 32'h2C);
      fwd_set(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
      step();
      chk("fwd x0 alu_a", alu_a, 32'h33);
      drive(7'h23, 3'b010, 1'b0, 5'd7, 5'd7, 5'd3, 32'h11, 32'h22, 32'd8, 32'h30);
      fwd_set(1'b1, 5'd4, 32'hAA, 1'b1, 5'd7, 32'hBB);
      step();
      chk("fwd wb rs2_data", out_rs2_data, FWD ? 32'hBB : 32'h22);
      fwd_set(1'b0, 5'd0, 0, 1'b0, 5'd0, 0);

      // Flush with capture
      drive(7'h33, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h99, 32'h1, 32'd0, 32'h34);
      flush = 1'b1;
      step();
      chk("flush out_valid", 32'(out_valid), 32'd0);
      flush = 1'b0;

      // Illegal opcode
      drive(7'h7F, 3'b000, 1'b0, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 32'h3, 32'h38);
      step();
      chk("illegal flag", 32'(out_illegal), 32'd1);
      chk("illegal alu_op", 32'(alu_op), 32'b0000);
      chk("illegal out_rd", 32'(out_rd), 32'd0);

      // Store / branch / jal / lui
      drive(7'h23, 3'b010, 1'b0, 5'd1, 5'd2, 5'd4, 32'h100, 32'hDEAD, 32'd8, 32'h3C);
      step();
      chk("store out_rd", 32'(out_rd), 32'd0);
      chk("store alu_b", alu_b, 32'd8);
      drive(7'h63, 3'b110, 1'b0, 5'd1, 5'd2, 5'd6, 32'h5, 32'h6, 32'h10, 32'h40);
      step();
      chk("bltu alu_op", 32'(alu_op), 32'b1001);
      in_funct3 = 3'b101;
      step();
      chk("bge alu_op", 32'(alu_op), 32'b0101);
      in_funct3 = 3'b001;
      step();
      chk("bne alu_op", 32'(alu_op), 32'b0001);
      drive(7'h6F, 3'b000, 1'b0, 5'd1, 5'd2, 5'd1, 32'h5, 32'h6, 32'h100, 32'h40);
      step();
      chk("jal alu_a", alu_a, 32'h40);
      chk("jal alu_b", alu_b, 32'd4);
      drive(7'h37, 3'b000, 1'b0, 5'd1, 5'd2, 5'd8, 32'h77, 32'h6, 32'h1234_5000, 32'h44);
      step();
      chk("lui alu_a", alu_a, 32'd0);

      // AUIPC, then drain
      drive(7'h17, 3'b000, 1'b0, 5'd1, 5'd2, 5'd8, 32'h77, 32'h6, 32'h2000, 32'h1000);
      step();
      chk("auipc alu_a", alu_a, 32'h1000);
      chk("auipc alu_b", alu_b, 32'h2000);
      chk("auipc alu_op", 32'(alu_op), 32'b0000);
      in_valid = 1'b0;
      step();
      chk("drain out_valid", 32'(out_valid), 32'd0);
      chk("drain alu_a", alu_a, 32'h1000);

      // Async reset while holding
      drive(7'h33, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h55, 32'h1, 32'd0, 32'h48);
      step();
      out_ready = 1'b0; in_valid = 1'b0;
      step();
      chk("pre-rst out_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async rst out_valid", 32'(out_valid), 32'd0);
      chk("async rst alu_a", alu_a, 32'd0);
      step();
      rst = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Accepts decoded RV32I fields from the decode stage and applies operand forwarding.
- Maps opcode/funct3/funct7 onto the ALU's 4-bit op encoding.
- Holds alu_a, alu_b and alu_op stable for the ALU under a valid/ready handshake, with flush support for branch redirect.

Parameters:
- XLEN, 32, datapath width of operands, pc and imm.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  decode has an instruction.
- in_ready  out  1  stage can accept; combinational: ~out_valid | out_ready.
- in_opcode  in  7  instruction bits [6:0].
- in_funct3  in  3  instruction bits [14:12].
- in_funct7_5  in  1  instruction bit 30.
- in_rs1, in_rs2, in_rd  in  5 each  register indices.
- in_rs1_data, in_rs2_data  in  XLEN each  register file read data.
- in_imm  in  XLEN  sign-extended immediate.
- in_pc  in  XLEN  instruction address.
- flush  in  1  kill the held and the incoming instruction.
- ex_fwd_valid, ex_fwd_rd, ex_fwd_data  in  1/5/XLEN  EX/MEM writeback forward.
- wb_fwd_valid, wb_fwd_rd, wb_fwd_data  in  1/5/XLEN  MEM/WB writeback forward.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  ALU/EX consumer accepts.
- alu_a, alu_b  out  XLEN each  ALU operands.
- alu_op  out  4  ALU operation code.
- out_rd  out  5  destination register index.
- out_pc  out  XLEN  instruction address.
- out_rs2_data  out  XLEN  store data, after forwarding.
- out_illegal  out  1  unsupported opcode.

Behaviour:
- Reset (async): out_valid=0; alu_a=alu_b=out_pc=out_rs2_data=0; alu_op=4'b0000; out_rd=0; out_illegal=0.
- alu_op encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, SLTU 1001.
- Capture: occurs when in_valid & in_ready & ~flush. All outputs register on that edge; latency is 1 cycle.
- Hold: while out_valid & ~out_ready, every output is held bit-stable.
- Drain: if out_valid & out_ready and no capture, out_valid goes to 0 on the next edge. Data outputs keep their last value.
- Flush: highest priority. On the next edge out_valid=0, and the input offered in the same cycle is dropped. in_ready keeps its normal formula.
- Forwarding, per source operand (rs1, rs2):
  - If ex_fwd_valid and ex_fwd_rd==rs and rs!=0, use ex_fwd_data.
  - Else if wb_fwd_valid and wb_fwd_rd==rs and rs!=0, use wb_fwd_data.
  - Else use the register file data. EX has priority over WB.
- Decode rules (a = forwarded rs1, r2 = forwarded rs2):
  - OP 0110011: a=rs1, b=r2. funct3 000 selects ADD, or SUB when funct7_5=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7_5=1; 110 OR; 111 AND.
  - OP-IMM 0010011: same mapping with b=imm. funct7_5 is honoured only for funct3=101; 000 is always ADD.
  - LUI 0110111: a=0, b=imm, ADD.
  - AUIPC 0010111: a=pc, b=imm, ADD.
  - LOAD 0000011 and STORE 0100011: a=rs1, b=imm, ADD.
  - BRANCH 1100011: a=rs1, b=r2. funct3 0xx selects SUB; 10x selects SLT; 11x selects SLTU.
  - JAL 1101111 and JALR 1100111: a=pc, b=4, ADD (link value).
  - Any other opcode: out_illegal=1, alu_op=ADD, a=b=0.
- out_rs2_data is always the forwarded rs2 value. out_rd is captured unchanged. out_rd is forced to 0 for STORE, BRANCH and illegal opcodes.
- Reset asserted mid-hold clears the stage immediately, without waiting for a clock edge.

Optional Feature:
- Macro ID_EX_FORWARD_EN.
- Defined: forwarding behaves as specified above.
- Undefined: forwarding ports remain present but are ignored. Operands come only from in_rs1_data/in_rs2_data, and the forwarding muxes are not synthesized.

Test Plan:
- Reset then OP ADD (rs1_data=5, rs2_data=3, funct3=000, f7_5=0), out_ready=1 -> 1 cycle later out_valid=1, alu_a=5, alu_b=3, alu_op=0000.
- OP-IMM SRAI (funct3=101, f7_5=1, imm=4, rs1_data=32'h80000000) -> alu_op=1000, alu_b=4. The same encoding with f7_5=0 gives 1000→0111.
- Hold: out_ready=0 for 3 cycles with a new in_valid presented -> in_ready=0 and outputs unchanged. out_ready=1 then accepts the next instruction on the following edge.
- Forwarding (macro defined): rs1=7, ex_fwd_rd=7 data=32'hAA, wb_fwd_rd=7 data=32'hBB -> alu_a=32'hAA. With rs1=0 and both forwards targeting rd 0 -> alu_a=in_rs1_data.
- Flush and capture in the same cycle -> out_valid=0 next cycle. Opcode 1111111 -> out_illegal=1, alu_op=0000, out_rd=0.
- AUIPC pc=32'h1000, imm=32'h2000 -> alu_a=32'h1000, alu_b=32'h2000, alu_op=0000. Async rst pulse mid-hold -> out_valid=0 with no clock edge required.
